// File: rtl/dm_lane_ctrl_if.sv
// Request/response bundle between the M-stage and the data-memory lane controller.
// The pipeline side is the master; the controller is the slave.
interface dm_lane_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic [2:0]  load_type;
  logic [1:0]  store_type;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_pc, load_type, store_type,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_pc, load_type, store_type,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );
endinterface

// File: rtl/dm_lane_ctrl.sv
// Word-organised data memory for the M stage: byte/half/word lanes, one-cycle response,
// alignment/range faults, and a zero-fill sweep after reset or clr.
module dm_lane_ctrl #(
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter bit          LOG_EN      = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clr,
  dm_lane_ctrl_if.slave  bus
);
  localparam int unsigned    AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [AW-1:0]  LAST_IDX = AW'(DEPTH_WORDS - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_init_cnt;
  logic          w_last;
  logic          w_req_ready;
  logic          w_init_busy;

  logic [31:0]   w_off;
  logic [29:0]   w_widx;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic          w_range_flt;
  logic          w_misal;
  logic          w_fault;
  logic          w_accept;
  logic          w_st_commit;
  logic          w_ld_fetch;
  logic [3:0]    w_st_be;
  logic [31:0]   w_st_data;

  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          r_vld_p1;
  logic          r_err_p1;
  logic          r_we_p1;
  logic [31:0]   r_word_p1;
  logic [1:0]    r_lane_p1;
  logic [2:0]    r_ltype_p1;

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  ltype);
    logic [31:0]        shifted;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] ext_s;
    logic [31:0]        res;
    shifted = word >> {lane, 3'b000};
    b_s     = signed'(shifted[7:0]);
    h_s     = signed'(lane[1] ? word[31:16] : word[15:0]);
    ext_s   = '0;
    res     = word;
    case (ltype)
      3'd1: begin ext_s = b_s; res = ext_s; end
      3'd2: res = {24'h0, shifted[7:0]};
      3'd3: begin ext_s = h_s; res = ext_s; end
      3'd4: res = {16'h0, h_s};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] data,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++)
      if (be[b]) res[8*b +: 8] = data[8*b +: 8];
    return res;
  endfunction

  // Address decode and fault detection happen in the accept cycle.
  assign w_off       = bus.req_addr - BASE_ADDR;
  assign w_widx      = w_off[31:2];
  assign w_idx       = w_widx[AW-1:0];
  assign w_lane      = w_off[1:0];
  assign w_range_flt = (bus.req_addr < BASE_ADDR) || ({2'b00, w_widx} >= 32'(DEPTH_WORDS));

  always_comb begin
    w_misal = 1'b0;
    if (bus.req_we) begin
      case (bus.store_type)
        2'd1:    w_misal = 1'b0;
        2'd2:    w_misal = w_lane[0];
        default: w_misal = (w_lane != 2'd0);
      endcase
    end else begin
      case (bus.load_type)
        3'd1, 3'd2: w_misal = 1'b0;
        3'd3, 3'd4: w_misal = w_lane[0];
        default:    w_misal = (w_lane != 2'd0);
      endcase
    end
  end

  assign w_fault     = w_range_flt | w_misal;
  assign w_accept    = bus.req_valid & w_req_ready;
  assign w_st_commit = w_accept & bus.req_we & ~w_fault;
  assign w_ld_fetch  = w_accept & ~bus.req_we & ~w_fault;

  always_comb begin
    w_st_be   = 4'b1111;
    w_st_data = bus.req_wdata;
    case (bus.store_type)
      2'd1: begin
        w_st_be   = 4'b0001 << w_lane;
        w_st_data = {4{bus.req_wdata[7:0]}};
      end
      2'd2: begin
        w_st_be   = w_lane[1] ? 4'b1100 : 4'b0011;
        w_st_data = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Controller FSM: state register, next state, outputs.
  assign w_last = (r_init_cnt == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_INIT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clr)
      w_state_nxt = ST_INIT;
    else if (r_state == ST_INIT && w_last)
      w_state_nxt = ST_RUN;
  end

  always_comb begin
    w_req_ready = 1'b0;
    w_init_busy = 1'b0;
    case (r_state)
      ST_INIT: w_init_busy = 1'b1;
      ST_RUN:  w_req_ready = ~clr;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_init_cnt <= '0;
    else if (r_state == ST_INIT && !clr && !w_last)
      r_init_cnt <= r_init_cnt + 1'b1;
    else
      r_init_cnt <= '0;
  end

  // Memory array: the sweep owns the write port while in INIT; stores use byte enables.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT)
      r_mem[r_init_cnt] <= '0;
    else if (w_st_commit)
      for (int b = 0; b < 4; b++)
        if (w_st_be[b]) r_mem[w_idx][8*b +: 8] <= w_st_data[8*b +: 8];
    if (w_ld_fetch)
      r_word_p1 <= r_mem[w_idx];
  end

  // Stage p1: response registers, one cycle after accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld_p1 <= 1'b0;
      r_err_p1 <= 1'b0;
      r_we_p1  <= 1'b0;
    end else begin
      r_vld_p1 <= w_accept;
      r_err_p1 <= w_accept & w_fault;
      r_we_p1  <= w_accept & bus.req_we;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lane_p1  <= w_lane;
      r_ltype_p1 <= bus.load_type;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.init_busy = w_init_busy;
  assign bus.rsp_valid = r_vld_p1;
  assign bus.rsp_err   = r_err_p1;
  assign bus.rsp_rdata = (r_vld_p1 && !r_err_p1 && !r_we_p1)
                         ? load_extract(r_word_p1, r_lane_p1, r_ltype_p1) : 32'h0;

`ifndef SYNTHESIS
  generate
    if (LOG_EN) begin : g_log
      always @(posedge clk) begin
        if (reset && w_st_commit)
          $display("%d@%h: *%h <= %h", $time, bus.req_pc, {bus.req_addr[31:2], 2'b00},
                   lane_merge(r_mem[w_idx], w_st_data, w_st_be));
      end
    end
  endgenerate
`endif

endmodule

// File: tb/tb_dm_lane_ctrl.sv
// Directed bench for dm_lane_ctrl: sweep timing, lane extraction, merges, faults, clr and reset.
module tb_dm_lane_ctrl;
  localparam int unsigned DEPTH = 3072;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic clr   = 1'b0;

  dm_lane_ctrl_if bus();

  dm_lane_ctrl #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LOG_EN(1'b1)) dut (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          nvec = 0;
  int          nerr = 0;
  logic        rv;
  logic        re;
  logic [31:0] rd;
  int          n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One accepted access; samples the response 1 ns after the accepting edge.
  task automatic acc(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [2:0] lt, input logic [1:0] st);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_pc     = 32'h0000_1000 + addr;
    bus.load_type  = lt;
    bus.store_type = st;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rv = bus.rsp_valid;
    re = bus.rsp_err;
    rd = bus.rsp_rdata;
  endtask

  task automatic ld_chk(input string tag, input logic [31:0] addr, input logic [2:0] lt,
                        input logic [31:0] exp_d, input logic exp_e);
    acc(1'b0, addr, 32'h0, lt, 2'd0);
    chk({tag, "_valid"}, 32'(rv), 32'd1);
    chk({tag, "_err"},   32'(re), 32'(exp_e));
    chk({tag, "_data"},  rd,      exp_d);
  endtask

  task automatic st_chk(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] st, input logic exp_e);
    acc(1'b1, addr, wd, 3'd0, st);
    chk({tag, "_valid"}, 32'(rv), 32'd1);
    chk({tag, "_err"},   32'(re), 32'(exp_e));
    chk({tag, "_data"},  rd,      32'h0);
  endtask

  // Counts clock edges while init_busy stays high, bounded past the expected length.
  task automatic wait_sweep(output int cnt);
    cnt = 0;
    while (bus.init_busy === 1'b1 && cnt < int'(DEPTH) + 16) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.req_pc     = 32'h0;
    bus.load_type  = 3'd0;
    bus.store_type = 2'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  32'(bus.init_busy), 32'd1);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rv",    32'(bus.rsp_valid), 32'd0);
    chk("rst_err",   32'(bus.rsp_err),   32'd0);
    chk("rst_rdata", bus.rsp_rdata,      32'h0);

    @(negedge clk) reset = 1'b1;
    wait_sweep(n);
    chk("sweep1_len", 32'(n), 32'(DEPTH));
    chk("run_ready",  32'(bus.req_ready), 32'd1);

    for (int i = 0; i < int'(DEPTH); i += 256)
      ld_chk("zero_lw", BASE + 32'(i * 4), 3'd0, 32'h0, 1'b0);

    @(posedge clk);
    #1;
    chk("idle_valid", 32'(bus.rsp_valid), 32'd0);
    chk("idle_data",  bus.rsp_rdata,      32'h0);

    st_chk("sw10",   32'h10, 32'h8765_4321, 2'd0, 1'b0);
    ld_chk("lb11",   32'h11, 3'd1, 32'h0000_0043, 1'b0);
    ld_chk("lbu13",  32'h13, 3'd2, 32'h0000_0087, 1'b0);
    ld_chk("lh12",   32'h12, 3'd3, 32'hFFFF_8765, 1'b0);
    ld_chk("lhu12",  32'h12, 3'd4, 32'h0000_8765, 1'b0);
    ld_chk("lb13",   32'h13, 3'd1, 32'hFFFF_FF87, 1'b0);
    ld_chk("lh10",   32'h10, 3'd3, 32'h0000_4321, 1'b0);
    ld_chk("lw10_t7", 32'h10, 3'd7, 32'h8765_4321, 1'b0);

    st_chk("sb1e",   32'h1E, 32'h1234_56AB, 2'd1, 1'b0);
    st_chk("sh1c",   32'h1C, 32'h9999_CDEF, 2'd2, 1'b0);
    ld_chk("lw1c",   32'h1C, 3'd0, 32'h00AB_CDEF, 1'b0);

    st_chk("sw20",      32'h20, 32'h1122_3344, 2'd0, 1'b0);
    ld_chk("lw22_mis",  32'h22, 3'd0, 32'h0, 1'b1);
    st_chk("sh21_mis",  32'h21, 32'h0000_FFFF, 2'd2, 1'b1);
    st_chk("sw_range",  BASE + 32'(DEPTH * 4), 32'hDEAD_BEEF, 2'd0, 1'b1);
    ld_chk("lw20_kept", 32'h20, 3'd0, 32'h1122_3344, 1'b0);
    ld_chk("lw_last",   BASE + 32'((DEPTH - 1) * 4), 3'd0, 32'h0, 1'b0);
    ld_chk("lhu21_mis", 32'h21, 3'd4, 32'h0, 1'b1);
    ld_chk("lb_range",  BASE + 32'(DEPTH * 4), 3'd1, 32'h0, 1'b1);

    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_addr   = 32'h40;
    bus.req_wdata  = 32'hDEAD_BEEF;
    bus.store_type = 2'd0;
    clr            = 1'b1;
    #1;
    chk("clr_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    clr           = 1'b0;
    bus.req_valid = 1'b0;
    chk("clr_valid", 32'(bus.rsp_valid), 32'd0);
    chk("clr_busy",  32'(bus.init_busy), 32'd1);
    wait_sweep(n);
    chk("sweep2_len", 32'(n), 32'(DEPTH));
    ld_chk("clr_lw10", 32'h10, 3'd0, 32'h0, 1'b0);
    ld_chk("clr_lw1c", 32'h1C, 3'd0, 32'h0, 1'b0);
    ld_chk("clr_lw20", 32'h20, 3'd0, 32'h0, 1'b0);
    ld_chk("clr_lw40", 32'h40, 3'd0, 32'h0, 1'b0);

    st_chk("sw10b", 32'h10, 32'h5555_AAAA, 2'd0, 1'b0);
    ld_chk("lw10b", 32'h10, 3'd0, 32'h5555_AAAA, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("arst_data",  bus.rsp_rdata,      32'h0);
    chk("arst_busy",  32'(bus.init_busy), 32'd1);
    chk("arst_ready", 32'(bus.req_ready), 32'd0);

    @(negedge clk) reset = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("mid_busy", 32'(bus.init_busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.init_busy), 32'd1);
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    wait_sweep(n);
    chk("sweep3_len", 32'(n), 32'(DEPTH));
    ld_chk("rst_lw10", 32'h10, 3'd0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
